// File: rtl/raizing_video_pkg.sv
// Shared definitions for the graphics ROM arbiter: FSM encoding, grant policy codes and an index-width helper.
// No logic, no latency, no flow control.
package raizing_video_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } arb_state_t;

    localparam int PRIO_RR    = 0;
    localparam int PRIO_FIXED = 1;

    // A single channel still needs a one-bit index.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/raizing_rr_pick.sv
// Grant picker: round-robin from last_grant+1, or lowest index first when mode is set.
// Purely combinational, no latency; any_vld low means nothing to grant.
module raizing_rr_pick #(
    parameter int NCH = 4,
    parameter int GW  = 2
) (
    input  logic [NCH-1:0] pend,
    input  logic [GW-1:0]  last_grant,
    input  logic           mode,
    output logic [GW-1:0]  grant,
    output logic           any_vld
);

    always_comb begin
        int idx;
        grant   = '0;
        any_vld = 1'b0;
        idx     = 0;
        for (int k = 0; k < NCH; k++) begin
            idx = mode ? k : (int'(last_grant) + 1 + k) % NCH;
            if (!any_vld && pend[idx]) begin
                grant   = idx[GW-1:0];
                any_vld = 1'b1;
            end
        end
    end

endmodule

// File: rtl/raizing_gfx_arbiter.sv
// Per-channel one-entry tag cache in front of a shared graphics ROM; hit REQ_OK in 1 cycle, miss 2 cycles after ROM_OK.
// Requesters hold REQ_CS until REQ_OK; one ROM request outstanding, held until ROM_OK with a low ROM_CS cycle between.
module raizing_gfx_arbiter
    import raizing_video_pkg::*;
#(
    parameter int NCH       = 4,
    parameter int AW        = 22,
    parameter int DW        = 32,
    parameter int PRIO_MODE = 0
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic [NCH-1:0]    REQ_CS,
    input  logic [NCH*AW-1:0] REQ_ADDR,
    output logic [NCH-1:0]    REQ_OK,
    output logic [NCH*DW-1:0] REQ_DOUT,
    output logic              ROM_CS,
    output logic [AW-1:0]     ROM_ADDR,
    input  logic              ROM_OK,
    input  logic [DW-1:0]     ROM_DATA
);

    localparam int            GW         = idx_width(NCH);
    localparam logic [GW-1:0] LAST_RST   = GW'(NCH - 1);
    localparam logic          FIXED_MODE = (PRIO_MODE == PRIO_FIXED);

    arb_state_t     state;
    logic [GW-1:0]  last_grant;
    logic [GW-1:0]  pick;
    logic           pick_vld;
    logic           armed;
    logic           abandoned;
    logic           req_drop;
    logic [DW-1:0]  cap_data;
    logic [NCH-1:0] hit;
    logic [NCH-1:0] pend;
    logic [NCH-1:0] wr_en;
    logic [AW-1:0]  addr_a [NCH];

    generate
        for (genvar i = 0; i < NCH; i++) begin : g_ch
            logic [AW-1:0] tag;
            logic          vld;
            logic [DW-1:0] dat;
            logic          ok_q;

            assign addr_a[i] = REQ_ADDR[i*AW +: AW];
            assign hit[i]    = REQ_CS[i] & vld & (addr_a[i] == tag);
            assign pend[i]   = REQ_CS[i] & ~hit[i];
            assign wr_en[i]  = (state == ST_DONE) & ~abandoned & (last_grant == GW'(i));
            assign REQ_OK[i] = ok_q;
            assign REQ_DOUT[i*DW +: DW] = dat;

            always_ff @(posedge CLK or posedge RESET) begin
                if (RESET) begin
                    tag  <= '0;
                    vld  <= 1'b0;
                    dat  <= '0;
                    ok_q <= 1'b0;
                end else begin
                    ok_q <= hit[i];
                    if (wr_en[i]) begin
                        tag <= ROM_ADDR;
                        vld <= 1'b1;
                        dat <= cap_data;
                    end
                end
            end
        end
    endgenerate

    raizing_rr_pick #(
        .NCH (NCH),
        .GW  (GW)
    ) u_pick (
        .pend       (pend),
        .last_grant (last_grant),
        .mode       (FIXED_MODE),
        .grant      (pick),
        .any_vld    (pick_vld)
    );

    // The granted requester walked away or moved on; its fetch must not land in the cache.
    assign req_drop = ~REQ_CS[last_grant] | (addr_a[last_grant] != ROM_ADDR);

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state      <= ST_IDLE;
            ROM_CS     <= 1'b0;
            ROM_ADDR   <= '0;
            last_grant <= LAST_RST;
            cap_data   <= '0;
            abandoned  <= 1'b0;
            armed      <= 1'b0;
        end else begin
            // One settling cycle after reset release before the first grant.
            armed <= 1'b1;
            case (state)
                ST_IDLE: begin
                    if (armed && pick_vld) begin
                        last_grant <= pick;
                        ROM_ADDR   <= addr_a[pick];
                        ROM_CS     <= 1'b1;
                        abandoned  <= 1'b0;
                        state      <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (req_drop) begin
                        abandoned <= 1'b1;
                    end
                    if (ROM_OK) begin
                        cap_data <= ROM_DATA;
                        ROM_CS   <= 1'b0;
                        state    <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_raizing_gfx_arbiter.sv
// Scoreboard bench: a round-robin instance driven by directed and random rounds, plus a fixed-priority instance.
// Expected ROM addresses and per-channel data are queued at stimulus time and popped by monitors.
module tb_raizing_gfx_arbiter;

    localparam int NCH = 4;
    localparam int AW  = 22;
    localparam int DW  = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [NCH-1:0]    req_cs;
    logic [NCH*AW-1:0] req_addr;
    logic [NCH-1:0]    req_ok;
    logic [NCH*DW-1:0] req_dout;
    logic              rom_cs;
    logic [AW-1:0]     rom_addr;
    logic              rom_ok;
    logic [DW-1:0]     rom_data;

    logic [NCH-1:0]    fp_cs;
    logic [NCH*AW-1:0] fp_addr;
    logic [NCH-1:0]    fp_ok;
    logic [NCH*DW-1:0] fp_dout;
    logic              fp_rom_cs;
    logic [AW-1:0]     fp_rom_addr;
    logic              fp_rom_ok;
    logic [DW-1:0]     fp_rom_data;

    raizing_gfx_arbiter #(.NCH(NCH), .AW(AW), .DW(DW), .PRIO_MODE(0)) dut (
        .CLK(clk), .RESET(rst), .REQ_CS(req_cs), .REQ_ADDR(req_addr), .REQ_OK(req_ok),
        .REQ_DOUT(req_dout), .ROM_CS(rom_cs), .ROM_ADDR(rom_addr), .ROM_OK(rom_ok), .ROM_DATA(rom_data)
    );

    raizing_gfx_arbiter #(.NCH(NCH), .AW(AW), .DW(DW), .PRIO_MODE(1)) dut_fp (
        .CLK(clk), .RESET(rst), .REQ_CS(fp_cs), .REQ_ADDR(fp_addr), .REQ_OK(fp_ok),
        .REQ_DOUT(fp_dout), .ROM_CS(fp_rom_cs), .ROM_ADDR(fp_rom_addr), .ROM_OK(fp_rom_ok), .ROM_DATA(fp_rom_data)
    );

    typedef struct {
        logic [DW-1:0] data;
        logic [AW-1:0] addr;
        bit            miss;
        int            issue;
    } exp_t;

    int            errors = 0;
    int            checks = 0;
    int            cyc    = 0;
    exp_t          exp_q [NCH][$];
    logic [AW-1:0] exp_rom[$];
    logic [AW-1:0] exp_rom2[$];
    logic [AW-1:0] mdl_tag [NCH];
    bit            mdl_vld [NCH];
    int            mdl_last;
    int            rom_lat = 3;
    bit            spur = 1'b0;

    function automatic logic [DW-1:0] rom_fn(input logic [AW-1:0] a);
        if (a == 22'h100) return 32'hDEADBEEF;
        return {a[9:0], a} ^ 32'h5A3C96E1;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail(input string name, input logic [63:0] act);
        checks++;
        errors++;
        $display("FAIL %s: got %0h with nothing expected (cycle %0d)", name, act, cyc);
    endtask

    task automatic model_reset();
        for (int c = 0; c < NCH; c++) begin
            mdl_vld[c] = 1'b0;
            mdl_tag[c] = '0;
            exp_q[c].delete();
        end
        exp_rom.delete();
        mdl_last = NCH - 1;
    endtask

    task automatic push_rom(input int ch, input logic [AW-1:0] a);
        exp_rom.push_back(a);
        mdl_last = ch;
    endtask

    task automatic request(input int ch, input logic [AW-1:0] a, input bit auto_rom);
        exp_t e;
        bit   miss;
        miss    = !(mdl_vld[ch] && mdl_tag[ch] == a);
        e.data  = rom_fn(a);
        e.addr  = a;
        e.miss  = miss;
        e.issue = cyc;
        exp_q[ch].push_back(e);
        if (miss) begin
            if (auto_rom) push_rom(ch, a);
            mdl_tag[ch] = a;
            mdl_vld[ch] = 1'b1;
        end
        req_addr[ch*AW +: AW] = a;
        req_cs[ch] = 1'b1;
    endtask

    task automatic wait_ok(input int ch);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            if (req_ok[ch]) seen = 1'b1;
            else @(negedge clk);
        end
        if (!seen) fail("ok_timeout", 64'(ch));
    endtask

    task automatic wait_rom_cs(input logic lvl);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            if (rom_cs == lvl) seen = 1'b1;
            else @(negedge clk);
        end
        if (!seen) fail("rom_cs_timeout", 64'(lvl));
    endtask

    // All selected channels raise CS together; misses are served round-robin from the last grant.
    task automatic round(input logic [NCH-1:0] mask, input logic [AW-1:0] addrs [NCH]);
        bit miss [NCH];
        int start;
        for (int c = 0; c < NCH; c++)
            miss[c] = mask[c] && !(mdl_vld[c] && mdl_tag[c] == addrs[c]);
        start = mdl_last;
        for (int k = 1; k <= NCH; k++) begin
            int c;
            c = (start + k) % NCH;
            if (miss[c]) push_rom(c, addrs[c]);
        end
        for (int c = 0; c < NCH; c++)
            if (mask[c]) request(c, addrs[c], 1'b0);
        for (int c = 0; c < NCH; c++)
            if (mask[c]) wait_ok(c);
        req_cs = '0;
        @(negedge clk);
    endtask

    // ROM model for the round-robin instance.
    initial begin
        int cnt;
        cnt      = -1;
        rom_ok   = 1'b0;
        rom_data = '0;
        forever begin
            @(negedge clk);
            rom_ok = 1'b0;
            if (rst) begin
                cnt = -1;
            end else begin
                if (rom_cs && cnt < 0) cnt = rom_lat;
                if (rom_cs && cnt == 0) begin
                    rom_ok   = 1'b1;
                    rom_data = rom_fn(rom_addr);
                    cnt      = -1;
                end else if (cnt > 0) begin
                    cnt--;
                end else if (spur && !rom_cs) begin
                    rom_ok   = 1'b1;
                    rom_data = 32'hBAD0BAD0;
                    spur     = 1'b0;
                end
            end
        end
    end

    // Monitor for the round-robin instance, sampled just after each rising edge.
    initial begin
        logic              prev_cs;
        logic [AW-1:0]     prev_addr;
        logic [NCH-1:0]    prev_ok;
        logic [NCH*DW-1:0] prev_dout;
        int                ok_edge [4];
        logic [AW-1:0]     ok_addr [4];
        exp_t              e;
        logic [DW-1:0]     d;
        prev_cs   = 1'b0;
        prev_addr = '0;
        prev_ok   = '0;
        prev_dout = '0;
        for (int i = 0; i < 4; i++) begin
            ok_edge[i] = -10;
            ok_addr[i] = '0;
        end
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (!rst) begin
                if (!prev_cs && rom_cs) begin
                    if (exp_rom.size() == 0) fail("rom_unexpected", 64'(rom_addr));
                    else check("rom_addr", 64'(rom_addr), 64'(exp_rom.pop_front()));
                end
                if (prev_cs && rom_ok) begin
                    check("rom_cs_fall", 64'(rom_cs), 64'd0);
                    ok_edge[cyc % 4] = cyc;
                    ok_addr[cyc % 4] = prev_addr;
                end else if (prev_cs && rom_cs) begin
                    check("rom_addr_stable", 64'(rom_addr), 64'(prev_addr));
                end
                for (int c = 0; c < NCH; c++) begin
                    d = req_dout[c*DW +: DW];
                    if (d !== prev_dout[c*DW +: DW]) begin
                        if (exp_q[c].size() == 0) fail("dout_unexpected", 64'(d));
                        else check("dout_load", 64'(d), 64'(exp_q[c][0].data));
                    end
                    if (req_ok[c] && !prev_ok[c]) begin
                        if (exp_q[c].size() == 0) begin
                            fail("ok_unexpected", 64'(c));
                        end else begin
                            e = exp_q[c].pop_front();
                            check("ok_data", 64'(d), 64'(e.data));
                            if (e.miss) begin
                                check("miss_latency", 64'(ok_edge[(cyc - 2) % 4]), 64'(cyc - 2));
                                check("miss_rom_addr", 64'(ok_addr[(cyc - 2) % 4]), 64'(e.addr));
                            end else begin
                                check("hit_latency", 64'(cyc - e.issue), 64'd1);
                            end
                        end
                    end
                end
            end
            prev_cs   = rom_cs;
            prev_addr = rom_addr;
            prev_ok   = req_ok;
            prev_dout = req_dout;
        end
    end

    // Monitor for the fixed-priority instance.
    initial begin
        logic prev_cs;
        logic prev_ok3;
        prev_cs  = 1'b0;
        prev_ok3 = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (!rst) begin
                if (!prev_cs && fp_rom_cs) begin
                    if (exp_rom2.size() == 0) fail("fp_rom_unexpected", 64'(fp_rom_addr));
                    else check("fp_rom_addr", 64'(fp_rom_addr), 64'(exp_rom2.pop_front()));
                end
                if (fp_ok[3] && !prev_ok3)
                    check("fp_ch3_data", 64'(fp_dout[3*DW +: DW]), 64'(rom_fn(22'h4F0)));
            end
            prev_cs  = fp_rom_cs;
            prev_ok3 = fp_ok[3];
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [AW-1:0] addrs [NCH];
        logic [NCH-1:0] mask;
        rst         = 1'b1;
        req_cs      = '0;
        req_addr    = '0;
        fp_cs       = '0;
        fp_addr     = '0;
        fp_rom_ok   = 1'b0;
        fp_rom_data = '0;
        model_reset();
        repeat (3) @(negedge clk);
        check("reset_rom_cs", 64'(rom_cs), 64'd0);
        check("reset_req_ok", 64'(req_ok), 64'd0);
        check("reset_dout", 64'(req_dout), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // Fairness from reset: four distinct misses come out 0,1,2,3.
        rom_lat = 3;
        addrs[0] = 22'h01000; addrs[1] = 22'h02000; addrs[2] = 22'h03000; addrs[3] = 22'h04000;
        round(4'hF, addrs);

        // Single miss with long ROM latency, then a hit on the same address.
        rom_lat = 5;
        request(1, 22'h00100, 1'b1);
        wait_ok(1);
        check("ch1_dout", 64'(req_dout[1*DW +: DW]), 64'h0DEADBEEF);
        req_cs[1] = 1'b0;
        @(negedge clk);
        request(1, 22'h00100, 1'b1);
        wait_ok(1);
        req_cs[1] = 1'b0;
        @(negedge clk);

        // Address moves during BUSY: stale fetch discarded, new address fetched.
        rom_lat = 4;
        push_rom(2, 22'h00010);
        push_rom(2, 22'h00020);
        begin
            exp_t e;
            e.data = rom_fn(22'h00020); e.addr = 22'h00020; e.miss = 1'b1; e.issue = cyc;
            exp_q[2].push_back(e);
        end
        req_addr[2*AW +: AW] = 22'h00010;
        req_cs[2] = 1'b1;
        wait_rom_cs(1'b1);
        @(negedge clk);
        req_addr[2*AW +: AW] = 22'h00020;
        mdl_tag[2] = 22'h00020;
        mdl_vld[2] = 1'b1;
        wait_ok(2);
        req_cs[2] = 1'b0;
        @(negedge clk);

        // CS dropped during BUSY: the same address must miss again afterwards.
        push_rom(2, 22'h00030);
        req_addr[2*AW +: AW] = 22'h00030;
        req_cs[2] = 1'b1;
        wait_rom_cs(1'b1);
        @(negedge clk);
        req_cs[2] = 1'b0;
        wait_rom_cs(1'b0);
        repeat (3) @(negedge clk);
        check("abandon_dout_kept", 64'(req_dout[2*DW +: DW]), 64'(rom_fn(22'h00020)));
        request(2, 22'h00030, 1'b1);
        wait_ok(2);
        req_cs[2] = 1'b0;
        @(negedge clk);

        // Spurious ROM_OK while idle.
        spur = 1'b1;
        repeat (4) @(negedge clk);
        check("spur_rom_cs", 64'(rom_cs), 64'd0);
        check("spur_req_ok", 64'(req_ok), 64'd0);
        request(0, mdl_tag[0], 1'b1);
        wait_ok(0);
        req_cs[0] = 1'b0;
        @(negedge clk);

        // Randomised rounds mixing hits and misses with varying ROM latency.
        for (int r = 0; r < 30; r++) begin
            rom_lat = $urandom_range(0, 4);
            mask = NCH'($urandom_range(1, 15));
            for (int c = 0; c < NCH; c++) begin
                if (mdl_vld[c] && $urandom_range(0, 2) == 0) addrs[c] = mdl_tag[c];
                else addrs[c] = AW'($urandom);
            end
            round(mask, addrs);
        end

        // Reset in the middle of a ROM cycle.
        rom_lat = 6;
        request(3, 22'h00300, 1'b1);
        wait_ok(3);
        req_cs[3] = 1'b0;
        @(negedge clk);
        push_rom(3, 22'h00310);
        req_addr[3*AW +: AW] = 22'h00310;
        req_cs[3] = 1'b1;
        wait_rom_cs(1'b1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst_mid_rom_cs", 64'(rom_cs), 64'd0);
        check("rst_mid_req_ok", 64'(req_ok), 64'd0);
        check("rst_mid_dout", 64'(req_dout), 64'd0);
        model_reset();
        req_addr[3*AW +: AW] = 22'h00300;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        request(3, 22'h00300, 1'b1);
        @(negedge clk);
        check("rst_first_edge_rom_cs", 64'(rom_cs), 64'd0);
        wait_ok(3);
        req_cs[3] = 1'b0;
        repeat (3) @(negedge clk);

        check("rom_queue_drained", 64'(exp_rom.size()), 64'd0);
        for (int c = 0; c < NCH; c++)
            check("ok_queue_drained", 64'(exp_q[c].size()), 64'd0);

        // Fixed priority: ch0 keeps moving to a new address while ch3 waits.
        begin
            int  cnt;
            int  served;
            bit  got;
            bit  just;
            cnt = -1; served = 0; got = 1'b0; just = 1'b0;
            exp_rom2.push_back(22'h00400);
            exp_rom2.push_back(22'h00401);
            exp_rom2.push_back(22'h00402);
            exp_rom2.push_back(22'h004F0);
            fp_addr[0 +: AW]    = 22'h00400;
            fp_addr[3*AW +: AW] = 22'h004F0;
            fp_cs[0] = 1'b1;
            fp_cs[3] = 1'b1;
            for (int i = 0; i < 300 && !got; i++) begin
                @(negedge clk);
                fp_rom_ok = 1'b0;
                if (just) begin
                    just = 1'b0;
                    if (served < 3) fp_addr[0 +: AW] = 22'h00400 + AW'(served);
                    else fp_cs[0] = 1'b0;
                end
                if (fp_rom_cs && cnt < 0) cnt = 2;
                if (fp_rom_cs && cnt == 0) begin
                    fp_rom_ok   = 1'b1;
                    fp_rom_data = rom_fn(fp_rom_addr);
                    cnt         = -1;
                    served++;
                    just        = 1'b1;
                end else if (cnt > 0) begin
                    cnt--;
                end
                if (fp_ok[3]) got = 1'b1;
            end
            if (!got) fail("fp_ch3_timeout", 64'(served));
            check("fp_services", 64'(served), 64'd4);
            fp_cs = '0;
            repeat (2) @(negedge clk);
            check("fp_rom_queue_drained", 64'(exp_rom2.size()), 64'd0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
